// File: rtl/frame_buf_port_arbiter.sv
// Round-robin burst scheduler for N write and M read frame-buffer ports in front of the SDRAM command core.
// Each port keeps its own address pointer; ping-pong mode alternates between two frame buffers.
module frame_buf_port_arbiter #(
  parameter int NUM_WR        = 2,
  parameter int NUM_RD        = 2,
  parameter int ADDR_W        = 24,
  parameter int LEN_W         = 9,
  parameter int RD_FIFO_DEPTH = 512,
  parameter int PINGPONG      = 0,
  parameter logic [ADDR_W-1:0] FRAME_OFS = 24'h100000,
  localparam int NP = NUM_WR + NUM_RD,
  localparam int PW = $clog2(NP)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_WR*ADDR_W-1:0] wr_base_i,
  input  logic [NUM_WR*ADDR_W-1:0] wr_max_i,
  input  logic [NUM_WR*LEN_W-1:0]  wr_len_i,
  input  logic [NUM_WR-1:0]        wr_load_i,
  input  logic [NUM_WR*LEN_W-1:0]  wr_level_i,
  input  logic [NUM_RD*ADDR_W-1:0] rd_base_i,
  input  logic [NUM_RD*ADDR_W-1:0] rd_max_i,
  input  logic [NUM_RD*LEN_W-1:0]  rd_len_i,
  input  logic [NUM_RD-1:0]        rd_load_i,
  input  logic [NUM_RD*LEN_W-1:0]  rd_level_i,
  output logic                     cmd_valid_o,
  input  logic                     cmd_ready_i,
  output logic                     cmd_write_o,
  output logic [ADDR_W-1:0]        cmd_addr_o,
  output logic [LEN_W-1:0]         cmd_len_o,
  output logic [PW-1:0]            cmd_port_o,
  input  logic                     cmd_done_i,
  output logic [NUM_WR-1:0]        wr_frame_done_o,
  output logic [NUM_RD-1:0]        rd_frame_done_o,
  output logic [NUM_WR-1:0]        wr_buf_sel_o,
  output logic [NUM_RD-1:0]        rd_buf_sel_o
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_BUSY} state_t;

  localparam logic [LEN_W:0] DEPTH = (LEN_W+1)'(RD_FIFO_DEPTH);

  logic [ADDR_W-1:0] base [NP];
  logic [ADDR_W-1:0] maxa [NP];
  logic [LEN_W-1:0]  len  [NP];
  logic [LEN_W-1:0]  lvl  [NP];
  logic [LEN_W-1:0]  eff  [NP];
  logic [NP-1:0]     load;
  logic [NP-1:0]     req;

  logic [ADDR_W-1:0] ptr_q [NP];
  logic [NP-1:0]     buf_q;
  logic [NP-1:0]     done_q;

  state_t            state_q, state_d;
  logic [PW-1:0]     rr_q, rr_d;
  logic              cmd_valid_q, cmd_valid_d;
  logic              cmd_write_q, cmd_write_d;
  logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
  logic [LEN_W-1:0]  cmd_len_q, cmd_len_d;
  logic [PW-1:0]     cmd_port_q, cmd_port_d;
  logic              kill_q, kill_d;

  logic              grant_found;
  logic [PW-1:0]     grant_idx;
  int                idx;
  logic              upd;
  logic [ADDR_W-1:0] next_ptr;
  logic              wrap;

  // Writes occupy port indices 0..NUM_WR-1, reads follow.
  for (genvar w = 0; w < NUM_WR; w++) begin : g_wr
    assign base[w] = wr_base_i[w*ADDR_W +: ADDR_W];
    assign maxa[w] = wr_max_i[w*ADDR_W +: ADDR_W];
    assign len[w]  = wr_len_i[w*LEN_W +: LEN_W];
    assign lvl[w]  = wr_level_i[w*LEN_W +: LEN_W];
    assign load[w] = wr_load_i[w];
  end

  for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
    assign base[NUM_WR+r] = rd_base_i[r*ADDR_W +: ADDR_W];
    assign maxa[NUM_WR+r] = rd_max_i[r*ADDR_W +: ADDR_W];
    assign len[NUM_WR+r]  = rd_len_i[r*LEN_W +: LEN_W];
    assign lvl[NUM_WR+r]  = rd_level_i[r*LEN_W +: LEN_W];
    assign load[NUM_WR+r] = rd_load_i[r];
  end

  // A burst never crosses the end of a frame, so the last one is shortened.
  for (genvar p = 0; p < NP; p++) begin : g_req
    logic [ADDR_W-1:0] remain;
    logic              active;
    assign remain = maxa[p] - ptr_q[p];
    assign eff[p] = (remain < ADDR_W'(len[p])) ? remain[LEN_W-1:0] : len[p];
    assign active = (base[p] < maxa[p]) && (ptr_q[p] < maxa[p]) && (eff[p] != '0);
    if (p < NUM_WR) begin : g_w
      assign req[p] = active && (lvl[p] >= eff[p]);
    end else begin : g_r
      assign req[p] = active && ((DEPTH - {1'b0, lvl[p]}) >= {1'b0, eff[p]});
    end
  end

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int k = 0; k < NP; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= NP) idx = idx - NP;
      if (!grant_found && req[idx]) begin
        grant_found = 1'b1;
        grant_idx   = PW'(idx);
      end
    end
  end

  assign next_ptr = ptr_q[cmd_port_q] + ADDR_W'(cmd_len_q);
  assign wrap     = next_ptr >= maxa[cmd_port_q];

  // A load on the in-flight port cancels the completion update of that burst.
  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    cmd_valid_d = cmd_valid_q;
    cmd_write_d = cmd_write_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_len_d   = cmd_len_q;
    cmd_port_d  = cmd_port_q;
    kill_d      = kill_q;
    upd         = 1'b0;
    case (state_q)
      S_IDLE: begin
        kill_d = 1'b0;
        if (grant_found) begin
          cmd_valid_d = 1'b1;
          cmd_write_d = grant_idx < PW'(NUM_WR);
          cmd_addr_d  = ptr_q[grant_idx] + (buf_q[grant_idx] ? FRAME_OFS : '0);
          cmd_len_d   = eff[grant_idx];
          cmd_port_d  = grant_idx;
          rr_d        = (grant_idx == PW'(NP-1)) ? '0 : grant_idx + PW'(1);
          kill_d      = load[grant_idx];
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        kill_d = kill_q | load[cmd_port_q];
        if (cmd_ready_i) begin
          cmd_valid_d = 1'b0;
          state_d     = S_BUSY;
        end
      end
      S_BUSY: begin
        kill_d = kill_q | load[cmd_port_q];
        if (cmd_done_i) begin
          upd     = !(kill_q | load[cmd_port_q]);
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      rr_q        <= '0;
      cmd_valid_q <= 1'b0;
      cmd_write_q <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_len_q   <= '0;
      cmd_port_q  <= '0;
      kill_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_write_q <= cmd_write_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_len_q   <= cmd_len_d;
      cmd_port_q  <= cmd_port_d;
      kill_q      <= kill_d;
    end
  end

  // A read wrap latches the buffer the paired writer last completed.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int p = 0; p < NP; p++) ptr_q[p] <= base[p];
      buf_q  <= '0;
      done_q <= '0;
    end else begin
      done_q <= '0;
      for (int p = 0; p < NP; p++) begin
        if (load[p]) begin
          ptr_q[p] <= base[p];
          buf_q[p] <= 1'b0;
        end else if (upd && (cmd_port_q == PW'(p))) begin
          if (wrap) begin
            ptr_q[p]  <= base[p];
            done_q[p] <= 1'b1;
            if (PINGPONG != 0) begin
              if (p < NUM_WR) buf_q[p] <= ~buf_q[p];
              else if (p - NUM_WR < NUM_WR) buf_q[p] <= ~buf_q[p - NUM_WR];
            end
          end else begin
            ptr_q[p] <= next_ptr;
          end
        end
      end
    end
  end

  assign cmd_valid_o     = cmd_valid_q;
  assign cmd_write_o     = cmd_write_q;
  assign cmd_addr_o      = cmd_addr_q;
  assign cmd_len_o       = cmd_len_q;
  assign cmd_port_o      = cmd_port_q;
  assign wr_frame_done_o = done_q[NUM_WR-1:0];
  assign rd_frame_done_o = done_q[NP-1:NUM_WR];
  assign wr_buf_sel_o    = buf_q[NUM_WR-1:0];
  assign rd_buf_sel_o    = buf_q[NP-1:NUM_WR];

endmodule

// File: tb/tb_frame_buf_port_arbiter.sv
// Directed bench for frame_buf_port_arbiter: 2 write + 2 read ports, ping-pong enabled.
module tb_frame_buf_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [47:0] wr_base, wr_max, rd_base, rd_max;
  logic [17:0] wr_len, wr_level, rd_len, rd_level;
  logic [1:0]  wr_load, rd_load;
  logic        cmd_valid, cmd_ready, cmd_write, cmd_done;
  logic [23:0] cmd_addr;
  logic [8:0]  cmd_len;
  logic [1:0]  cmd_port;
  logic [1:0]  wr_frame_done, rd_frame_done, wr_buf_sel, rd_buf_sel;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  frame_buf_port_arbiter #(
    .NUM_WR(2), .NUM_RD(2), .ADDR_W(24), .LEN_W(9), .RD_FIFO_DEPTH(512),
    .PINGPONG(1), .FRAME_OFS(24'h100000)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .wr_base_i(wr_base), .wr_max_i(wr_max), .wr_len_i(wr_len),
    .wr_load_i(wr_load), .wr_level_i(wr_level),
    .rd_base_i(rd_base), .rd_max_i(rd_max), .rd_len_i(rd_len),
    .rd_load_i(rd_load), .rd_level_i(rd_level),
    .cmd_valid_o(cmd_valid), .cmd_ready_i(cmd_ready), .cmd_write_o(cmd_write),
    .cmd_addr_o(cmd_addr), .cmd_len_o(cmd_len), .cmd_port_o(cmd_port),
    .cmd_done_i(cmd_done),
    .wr_frame_done_o(wr_frame_done), .rd_frame_done_o(rd_frame_done),
    .wr_buf_sel_o(wr_buf_sel), .rd_buf_sel_o(rd_buf_sel)
  );

  task automatic cfg(input int p, input logic [23:0] b, input logic [23:0] m, input logic [8:0] l);
    if (p < 2) begin
      wr_base[p*24 +: 24] = b;
      wr_max[p*24 +: 24]  = m;
      wr_len[p*9 +: 9]    = l;
    end else begin
      rd_base[(p-2)*24 +: 24] = b;
      rd_max[(p-2)*24 +: 24]  = m;
      rd_len[(p-2)*9 +: 9]    = l;
    end
  endtask

  task automatic clear_cfg();
    for (int p = 0; p < 4; p++) cfg(p, 24'h0, 24'h0, 9'd256);
    wr_level = '0;
    rd_level = '0;
    wr_load  = '0;
    rd_load  = '0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1; cmd_ready = 1'b0; cmd_done = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Acts as the command core: waits for a command, accepts it, then completes it.
  task automatic serve(output bit got, output logic [23:0] a, output logic [8:0] l,
                       output logic [1:0] pt, output logic w,
                       output logic [1:0] wfd, output logic [1:0] rfd);
    got = 1'b0; a = '0; l = '0; pt = '0; w = 1'b0; wfd = '0; rfd = '0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (cmd_valid === 1'b1) got = 1'b1;
    end
    if (got) begin
      a = cmd_addr; l = cmd_len; pt = cmd_port; w = cmd_write;
      cmd_ready = 1'b1;
      @(negedge clk);
      cmd_ready = 1'b0;
      cmd_done  = 1'b1;
      @(negedge clk);
      cmd_done = 1'b0;
      wfd = wr_frame_done;
      rfd = rd_frame_done;
    end
  endtask

  task automatic test_reset();
    clear_cfg();
    pulse_reset();
    @(negedge clk);
    checks++;
    if ({cmd_valid, cmd_write, cmd_addr, cmd_len, cmd_port} !== 37'd0) begin
      errors++;
      $display("[TB] FAIL reset_cmd: got v=%b w=%b a=%h l=%0d p=%0d want all zero",
               cmd_valid, cmd_write, cmd_addr, cmd_len, cmd_port);
    end
    checks++;
    if ({wr_buf_sel, rd_buf_sel, wr_frame_done, rd_frame_done} !== 8'd0) begin
      errors++;
      $display("[TB] FAIL reset_status: got %b want 00000000",
               {wr_buf_sel, rd_buf_sel, wr_frame_done, rd_frame_done});
    end
  endtask

  task automatic test_round_robin();
    bit got; logic [23:0] a; logic [8:0] l; logic [1:0] pt, wfd, rfd; logic w;
    logic [23:0] ea; logic [1:0] ep; logic ew;
    clear_cfg();
    cfg(0, 24'h000000, 24'h001000, 9'd256);
    cfg(1, 24'h010000, 24'h011000, 9'd256);
    cfg(2, 24'h020000, 24'h021000, 9'd256);
    cfg(3, 24'h030000, 24'h031000, 9'd256);
    wr_level = {9'd300, 9'd300};
    rd_level = {9'd0, 9'd0};
    pulse_reset();
    for (int k = 0; k < 8; k++) begin
      serve(got, a, l, pt, w, wfd, rfd);
      ep = 2'(k % 4);
      ea = 24'((k % 4) * 32'h10000 + (k / 4) * 256);
      ew = (k % 4) < 2;
      checks++;
      if (!got || pt !== ep) begin
        errors++;
        $display("[TB] FAIL rr_port[%0d]: got %0d (seen=%0b) want %0d", k, pt, got, ep);
      end
      checks++;
      if (!got || {w, a, l} !== {ew, ea, 9'd256}) begin
        errors++;
        $display("[TB] FAIL rr_cmd[%0d]: got w=%b a=%h l=%0d want w=%b a=%h l=256", k, w, a, l, ew, ea);
      end
    end
  endtask

  task automatic test_frame_wrap();
    bit got; logic [23:0] a; logic [8:0] l; logic [1:0] pt, wfd, rfd; logic w;
    logic [23:0] ea [4];
    logic [8:0]  el [4];
    logic [1:0]  ef [4];
    ea = '{24'h000000, 24'h000100, 24'h000200, 24'h100000};
    el = '{9'd256, 9'd256, 9'd128, 9'd256};
    ef = '{2'b00, 2'b00, 2'b01, 2'b00};
    clear_cfg();
    cfg(0, 24'h0, 24'd640, 9'd256);
    wr_level = {9'd0, 9'd300};
    pulse_reset();
    for (int k = 0; k < 4; k++) begin
      serve(got, a, l, pt, w, wfd, rfd);
      checks++;
      if (!got || {a, l} !== {ea[k], el[k]}) begin
        errors++;
        $display("[TB] FAIL wrap_cmd[%0d]: got a=%h l=%0d want a=%h l=%0d", k, a, l, ea[k], el[k]);
      end
      checks++;
      if (wfd !== ef[k]) begin
        errors++;
        $display("[TB] FAIL wrap_frame_done[%0d]: got %b want %b", k, wfd, ef[k]);
      end
      if (k == 2) begin
        checks++;
        if (wr_buf_sel !== 2'b01) begin
          errors++;
          $display("[TB] FAIL wrap_buf_sel: got %b want 01", wr_buf_sel);
        end
        @(negedge clk);
        checks++;
        if (wr_frame_done !== 2'b00) begin
          errors++;
          $display("[TB] FAIL wrap_pulse_width: got %b want 00", wr_frame_done);
        end
      end
    end
  endtask

  task automatic test_rd_threshold();
    bit got; logic [23:0] a; logic [8:0] l; logic [1:0] pt, wfd, rfd; logic w;
    logic seen;
    clear_cfg();
    cfg(3, 24'h2000, 24'h3000, 9'd256);
    rd_level = {9'd300, 9'd0};
    pulse_reset();
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      seen = seen | cmd_valid;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rd_no_request: got cmd_valid=%b want 0", seen);
    end
    rd_level[9 +: 9] = 9'd256;
    @(negedge clk);
    checks++;
    if ({cmd_valid, cmd_write, cmd_port, cmd_addr, cmd_len} !== {1'b1, 1'b0, 2'd3, 24'h2000, 9'd256}) begin
      errors++;
      $display("[TB] FAIL rd_request_latency: got v=%b w=%b p=%0d a=%h l=%0d want v=1 w=0 p=3 a=002000 l=256",
               cmd_valid, cmd_write, cmd_port, cmd_addr, cmd_len);
    end
    serve(got, a, l, pt, w, wfd, rfd);
  endtask

  task automatic test_ready_stall();
    bit got; logic [23:0] a; logic [8:0] l; logic [1:0] pt, wfd, rfd; logic w;
    logic seen;
    clear_cfg();
    cfg(1, 24'h000500, 24'h010000, 9'd100);
    wr_level = {9'd200, 9'd0};
    pulse_reset();
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = cmd_valid;
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({seen, cmd_valid, cmd_write, cmd_port, cmd_addr, cmd_len} !==
          {1'b1, 1'b1, 1'b1, 2'd1, 24'h000500, 9'd100}) begin
        errors++;
        $display("[TB] FAIL stall_hold[%0d]: got v=%b w=%b p=%0d a=%h l=%0d want v=1 w=1 p=1 a=000500 l=100",
                 i, cmd_valid, cmd_write, cmd_port, cmd_addr, cmd_len);
      end
      @(negedge clk);
    end
    serve(got, a, l, pt, w, wfd, rfd);
    wr_level = '0;
    checks++;
    if (!got || a !== 24'h000500) begin
      errors++;
      $display("[TB] FAIL stall_accept: got a=%h (seen=%0b) want 000500", a, got);
    end
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      seen = seen | cmd_valid;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("[TB] FAIL stall_single_burst: got cmd_valid=%b want 0", seen);
    end
    wr_level = {9'd200, 9'd0};
    serve(got, a, l, pt, w, wfd, rfd);
    checks++;
    if (!got || a !== 24'h000564) begin
      errors++;
      $display("[TB] FAIL stall_next_addr: got a=%h (seen=%0b) want 000564", a, got);
    end
  endtask

  task automatic test_pingpong();
    bit got; logic [23:0] a; logic [8:0] l; logic [1:0] pt, wfd, rfd; logic w;
    logic [23:0] ea [10];
    ea = '{24'h000000, 24'h000000, 24'h000100, 24'h000100, 24'h100000,
           24'h000000, 24'h100100, 24'h000100, 24'h000000, 24'h100000};
    clear_cfg();
    cfg(0, 24'h0, 24'd512, 9'd256);
    cfg(2, 24'h0, 24'd512, 9'd256);
    wr_level = {9'd0, 9'd300};
    pulse_reset();
    for (int k = 0; k < 10; k++) begin
      serve(got, a, l, pt, w, wfd, rfd);
      checks++;
      if (!got || {pt, a} !== {((k % 2) == 0) ? 2'd0 : 2'd2, ea[k]}) begin
        errors++;
        $display("[TB] FAIL pp_cmd[%0d]: got p=%0d a=%h want p=%0d a=%h",
                 k, pt, a, ((k % 2) == 0) ? 0 : 2, ea[k]);
      end
      if (k == 2 || k == 6) begin
        checks++;
        if ({wr_buf_sel, wfd} !== {(k == 2) ? 2'b01 : 2'b00, 2'b01}) begin
          errors++;
          $display("[TB] FAIL pp_wr_wrap[%0d]: got buf=%b fd=%b want buf=%b fd=01",
                   k, wr_buf_sel, wfd, (k == 2) ? 2'b01 : 2'b00);
        end
      end
      if (k == 3 || k == 7) begin
        checks++;
        if ({rd_buf_sel, rfd} !== {(k == 3) ? 2'b00 : 2'b01, 2'b01}) begin
          errors++;
          $display("[TB] FAIL pp_rd_wrap[%0d]: got buf=%b fd=%b want buf=%b fd=01",
                   k, rd_buf_sel, rfd, (k == 3) ? 2'b00 : 2'b01);
        end
      end
    end
  endtask

  task automatic test_load_busy();
    bit got; logic [23:0] a; logic [8:0] l; logic [1:0] pt, wfd, rfd; logic w;
    logic seen;
    logic [1:0] fd;
    clear_cfg();
    cfg(0, 24'h000040, 24'h001000, 9'd256);
    wr_level = {9'd0, 9'd300};
    pulse_reset();
    serve(got, a, l, pt, w, wfd, rfd);
    checks++;
    if (!got || a !== 24'h000040) begin
      errors++;
      $display("[TB] FAIL load_first: got a=%h (seen=%0b) want 000040", a, got);
    end
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = cmd_valid;
    end
    checks++;
    if (!seen || cmd_addr !== 24'h000140) begin
      errors++;
      $display("[TB] FAIL load_second: got a=%h (seen=%0b) want 000140", cmd_addr, seen);
    end
    cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
    wr_load   = 2'b01;
    fd = '0;
    @(negedge clk);
    wr_load = 2'b00;
    fd = fd | wr_frame_done;
    @(negedge clk);
    fd = fd | wr_frame_done;
    @(negedge clk);
    cmd_done = 1'b1;
    fd = fd | wr_frame_done;
    @(negedge clk);
    cmd_done = 1'b0;
    fd = fd | wr_frame_done;
    checks++;
    if ({fd, wr_buf_sel} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL load_no_frame_done: got fd=%b buf=%b want fd=00 buf=00", fd, wr_buf_sel);
    end
    serve(got, a, l, pt, w, wfd, rfd);
    checks++;
    if (!got || a !== 24'h000040) begin
      errors++;
      $display("[TB] FAIL load_wins: got a=%h (seen=%0b) want 000040", a, got);
    end
  endtask

  task automatic test_reset_issue();
    bit got; logic [23:0] a; logic [8:0] l; logic [1:0] pt, wfd, rfd; logic w;
    logic seen;
    clear_cfg();
    cfg(0, 24'h000080, 24'h001000, 9'd16);
    wr_level = {9'd0, 9'd300};
    pulse_reset();
    serve(got, a, l, pt, w, wfd, rfd);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = cmd_valid;
    end
    checks++;
    if (!got || !seen || {a, cmd_addr} !== {24'h000080, 24'h000090}) begin
      errors++;
      $display("[TB] FAIL rst_pre: got a0=%h a1=%h want a0=000080 a1=000090", a, cmd_addr);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (cmd_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rst_issue_drop: got cmd_valid=%b want 0", cmd_valid);
    end
    rst      = 1'b0;
    cmd_done = 1'b1;
    @(negedge clk);
    cmd_done = 1'b0;
    checks++;
    if ({cmd_valid, cmd_addr} !== {1'b1, 24'h000080}) begin
      errors++;
      $display("[TB] FAIL rst_ptr_base: got v=%b a=%h want v=1 a=000080", cmd_valid, cmd_addr);
    end
    serve(got, a, l, pt, w, wfd, rfd);
    serve(got, a, l, pt, w, wfd, rfd);
    checks++;
    if (!got || a !== 24'h000090) begin
      errors++;
      $display("[TB] FAIL rst_late_done: got a=%h (seen=%0b) want 000090", a, got);
    end
  endtask

  task automatic test_zero_length();
    logic seen;
    clear_cfg();
    cfg(1, 24'h000200, 24'h000100, 9'd256);
    cfg(2, 24'h000300, 24'h000300, 9'd256);
    wr_level = {9'd300, 9'd300};
    pulse_reset();
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      seen = seen | cmd_valid;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("[TB] FAIL zero_length: got cmd_valid=%b want 0", seen);
    end
  endtask

  initial begin
    cmd_ready = 1'b0;
    cmd_done  = 1'b0;
    clear_cfg();
    test_reset();
    test_round_robin();
    test_frame_wrap();
    test_rd_threshold();
    test_ready_stall();
    test_pingpong();
    test_load_busy();
    test_reset_issue();
    test_zero_length();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
